// File: rtl/pipeline_fetch_stage.sv
// Instruction fetch stage: owns the PC, keeps one request outstanding to
// instruction memory and hands fetched words to the decoder latch through an
// output register backed by a one-entry skid buffer.
module pipeline_fetch_stage #(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              fetch_en,
   input  logic              jmpctrl_en,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              imem_req,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic              imem_ack,
   input  logic [31:0]       imem_rdata,
   output logic              out_valid,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_pc
);

   localparam logic [ADDR_W-1:0] PcStep = ADDR_W'(4);

   typedef enum logic [1:0] {StIdle, StReq, StDrain} state_e;

   state_e            r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [ADDR_W-1:0] r_req_addr;
   logic              r_imem_req;
   logic              r_out_valid;
   logic [31:0]       r_out_instr;
   logic [ADDR_W-1:0] r_out_pc;
   logic              r_skid_valid;
   logic [31:0]       r_skid_instr;
   logic [ADDR_W-1:0] r_skid_pc;

   logic [ADDR_W-1:0] w_redirect_pc;
   logic [ADDR_W-1:0] w_next_addr;
   logic              w_slot_free;
   logic              w_can_issue;
   logic              w_ack_word;
   logic              w_skid_valid_d;
   logic              w_unused_pc_lsb;

   // Redirect targets are always word-aligned; the low bits are dropped.
   assign w_redirect_pc   = {redirect_pc[ADDR_W-1:2], 2'b00};
   assign w_unused_pc_lsb = ^redirect_pc[1:0];
   assign w_next_addr     = r_req_addr + PcStep;

   assign w_slot_free = !r_out_valid || fetch_en;
   assign w_can_issue = !jmpctrl_en && !r_skid_valid && !redirect_valid;
   // A fresh word is only accepted for a live request that is not being redirected.
   assign w_ack_word  = (r_state == StReq) && imem_ack && !redirect_valid;

   assign imem_req  = r_imem_req;
   assign imem_addr = r_req_addr;
   assign out_valid = r_out_valid;
   assign out_instr = r_out_instr;
   assign out_pc    = r_out_pc;

   // Skid occupancy after this edge; decides whether streaming may continue.
   always_comb begin
      w_skid_valid_d = 1'b0;
      if (!redirect_valid) begin
         if (w_slot_free) begin
            w_skid_valid_d = r_skid_valid && w_ack_word;
         end else begin
            w_skid_valid_d = r_skid_valid || w_ack_word;
         end
      end
   end

   // Request FSM: PC, request address and registered request strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= StIdle;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_imem_req <= 1'b0;
      end else begin
         case (r_state)
            StIdle: begin
               if (redirect_valid) begin
                  r_pc <= w_redirect_pc;
               end else if (w_can_issue) begin
                  r_req_addr <= r_pc;
                  r_imem_req <= 1'b1;
                  r_state    <= StReq;
               end
            end
            StReq: begin
               if (redirect_valid) begin
                  r_pc <= w_redirect_pc;
                  if (imem_ack) begin
                     r_imem_req <= 1'b0;
                     r_state    <= StIdle;
                  end else begin
                     // Request cannot be withdrawn; wait out the stale ack.
                     r_state <= StDrain;
                  end
               end else if (imem_ack) begin
                  r_pc <= w_next_addr;
                  if (!jmpctrl_en && !w_skid_valid_d) begin
                     r_req_addr <= w_next_addr;
                  end else begin
                     r_imem_req <= 1'b0;
                     r_state    <= StIdle;
                  end
               end
            end
            StDrain: begin
               if (redirect_valid) begin
                  r_pc <= w_redirect_pc;
               end
               if (imem_ack) begin
                  r_imem_req <= 1'b0;
                  r_state    <= StIdle;
               end
            end
            default: begin
               r_imem_req <= 1'b0;
               r_state    <= StIdle;
            end
         endcase
      end
   end

   // Output register and skid buffer: skid drains first, new words fill behind it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid  <= 1'b0;
         r_out_instr  <= '0;
         r_out_pc     <= '0;
         r_skid_valid <= 1'b0;
         r_skid_instr <= '0;
         r_skid_pc    <= '0;
      end else begin
         r_skid_valid <= w_skid_valid_d;
         if (redirect_valid) begin
            r_out_valid <= 1'b0;
         end else if (w_slot_free) begin
            if (r_skid_valid) begin
               r_out_valid <= 1'b1;
               r_out_instr <= r_skid_instr;
               r_out_pc    <= r_skid_pc;
               if (w_ack_word) begin
                  r_skid_instr <= imem_rdata;
                  r_skid_pc    <= r_req_addr;
               end
            end else if (w_ack_word) begin
               r_out_valid <= 1'b1;
               r_out_instr <= imem_rdata;
               r_out_pc    <= r_req_addr;
            end else begin
               r_out_valid <= 1'b0;
            end
         end else if (w_ack_word) begin
            r_skid_instr <= imem_rdata;
            r_skid_pc    <= r_req_addr;
         end
      end
   end

endmodule

// File: tb/tb_pipeline_fetch_stage.sv
// Bench for pipeline_fetch_stage: directed stimulus, a transaction-level model
// (delivery queue plus outstanding-request flags) checked every cycle, and
// literal expectations at the interesting points.
module tb_pipeline_fetch_stage;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // Main instance, 32-bit addresses, RESET_PC = 0x100.
   logic        rst_n, fetch_en, jmpctrl_en, redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req, imem_ack, out_valid;
   logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;

   // Narrow instance for address wrap-around.
   logic        n8_rst_n, n8_imem_req, n8_imem_ack, n8_out_valid;
   logic [7:0]  n8_imem_addr, n8_out_pc;
   logic [31:0] n8_imem_rdata, n8_out_instr;

   pipeline_fetch_stage #(.ADDR_W(32), .RESET_PC(32'h100)) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_en       (fetch_en),
      .jmpctrl_en     (jmpctrl_en),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc)
   );

   pipeline_fetch_stage #(.ADDR_W(8), .RESET_PC(8'hF8)) u_dut8 (
      .clk            (clk),
      .rst_n          (n8_rst_n),
      .fetch_en       (1'b1),
      .jmpctrl_en     (1'b0),
      .redirect_valid (1'b0),
      .redirect_pc    (8'h00),
      .imem_req       (n8_imem_req),
      .imem_addr      (n8_imem_addr),
      .imem_ack       (n8_imem_ack),
      .imem_rdata     (n8_imem_rdata),
      .out_valid      (n8_out_valid),
      .out_instr      (n8_out_instr),
      .out_pc         (n8_out_pc)
   );

   int n_checks = 0;
   int n_pass   = 0;

   // Memory responder state.
   int mem_lat = 1;
   int mem_cnt = 0;

   // Model: delivery queue (head = output register, second = skid) and request flags.
   logic [31:0] m_pc, m_addr;
   bit          m_req, m_stale;
   logic [31:0] q_instr[$];
   logic [31:0] q_pc[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'hC0DE_0000 | {16'h0000, a[15:0]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic model_reset();
      m_pc    = 32'h100;
      m_addr  = 32'h100;
      m_req   = 1'b0;
      m_stale = 1'b0;
      q_instr.delete();
      q_pc.delete();
   endtask

   task automatic compare();
      chk("imem_req", {31'b0, imem_req}, {31'b0, m_req});
      if (m_req) chk("imem_addr", imem_addr, m_addr);
      chk("out_valid", {31'b0, out_valid}, (q_pc.size() > 0) ? 32'd1 : 32'd0);
      if (q_pc.size() > 0) begin
         chk("out_pc", out_pc, q_pc[0]);
         chk("out_instr", out_instr, q_instr[0]);
      end
   endtask

   task automatic model_step(input bit fe, input bit jc, input bit rv, input logic [31:0] rpc,
                             input bit ack, input logic [31:0] rdata);
      logic [31:0] tgt;
      int          old_n;
      bit          word;
      tgt   = {rpc[31:2], 2'b00};
      old_n = q_pc.size();
      word  = m_req && ack && !m_stale && !rv;
      // Delivery: consumer pops the head, a fresh word queues behind; redirect flushes.
      if (rv) begin
         q_instr.delete();
         q_pc.delete();
      end else begin
         if (fe && q_pc.size() > 0) begin
            void'(q_instr.pop_front());
            void'(q_pc.pop_front());
         end
         if (word) begin
            q_instr.push_back(rdata);
            q_pc.push_back(m_addr);
         end
      end
      // Requests: only issue when the queue has room for the reply.
      if (!m_req) begin
         if (rv) m_pc = tgt;
         else if (!jc && old_n < 2) begin
            m_req  = 1'b1;
            m_addr = m_pc;
         end
      end else if (m_stale) begin
         if (rv) m_pc = tgt;
         if (ack) begin
            m_req   = 1'b0;
            m_stale = 1'b0;
         end
      end else if (rv) begin
         m_pc = tgt;
         if (ack) m_req = 1'b0;
         else m_stale = 1'b1;
      end else if (ack) begin
         m_pc = m_addr + 32'd4;
         if (!jc && q_pc.size() < 2) m_addr = m_addr + 32'd4;
         else m_req = 1'b0;
      end
   endtask

   // One clock cycle: check, drive inputs and memory replies, advance model.
   task automatic cyc(input bit fe, input bit jc, input bit rv, input logic [31:0] rpc);
      bit          ack;
      logic [31:0] rd;
      compare();
      ack = 1'b0;
      rd  = 32'hDEAD_BEEF;
      if (imem_req) begin
         if (mem_cnt >= mem_lat - 1) begin
            ack     = 1'b1;
            rd      = mem_word(imem_addr);
            mem_cnt = 0;
         end else begin
            mem_cnt++;
         end
      end else begin
         mem_cnt = 0;
      end
      fetch_en       = fe;
      jmpctrl_en     = jc;
      redirect_valid = rv;
      redirect_pc    = rpc;
      imem_ack       = ack;
      imem_rdata     = rd;
      n8_imem_ack    = n8_imem_req;
      n8_imem_rdata  = mem_word({24'h0, n8_imem_addr});
      model_step(fe, jc, rv, rpc, ack, rd);
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0; n8_rst_n = 1'b0;
      fetch_en = 1'b0; jmpctrl_en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      imem_ack = 1'b0; imem_rdata = '0; n8_imem_ack = 1'b0; n8_imem_rdata = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_instr", out_instr, 32'h0);
      chk("rst_pc", out_pc, 32'h0);
      rst_n = 1'b1;

      // Reset and streaming with 1-cycle memory.
      cyc(1, 0, 0, 0);
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h100);
      cyc(1, 0, 0, 0);
      chk("stream0_valid", {31'b0, out_valid}, 32'd1);
      chk("stream0_pc", out_pc, 32'h100);
      chk("stream0_instr", out_instr, 32'hC0DE_0100);
      cyc(1, 0, 0, 0);
      chk("stream1_pc", out_pc, 32'h104);
      cyc(1, 0, 0, 0);
      chk("stream2_pc", out_pc, 32'h108);

      // Stall: one more word goes to the skid, request drops.
      cyc(0, 0, 0, 0);
      chk("stall_req_low", {31'b0, imem_req}, 32'd0);
      chk("stall_pc", out_pc, 32'h108);
      cyc(0, 0, 0, 0);
      cyc(0, 0, 0, 0);
      chk("stall_frozen", out_pc, 32'h108);
      cyc(1, 0, 0, 0);
      chk("skid_out_pc", out_pc, 32'h10C);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("resume_pc", out_pc, 32'h110);

      // Redirect while waiting on a 3-cycle memory.
      mem_lat = 3;
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h2002);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("redir_req", {31'b0, imem_req}, 32'd1);
      chk("redir_addr", imem_addr, 32'h2000);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("redir_wait_invalid", {31'b0, out_valid}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("redir_out_pc", out_pc, 32'h2000);
      chk("redir_out_instr", out_instr, 32'hC0DE_2000);

      // Redirect in the same cycle as the ack.
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h3000);
      chk("ackredir_drop", {31'b0, out_valid}, 32'd0);
      chk("ackredir_idle", {31'b0, imem_req}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("ackredir_req", {31'b0, imem_req}, 32'd1);
      chk("ackredir_addr", imem_addr, 32'h3000);

      // jmpctrl_en: in-flight word delivered, no new issue.
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      cyc(1, 1, 0, 0);
      chk("jmp_deliver_pc", out_pc, 32'h3000);
      chk("jmp_deliver_valid", {31'b0, out_valid}, 32'd1);
      chk("jmp_req_low", {31'b0, imem_req}, 32'd0);
      cyc(1, 1, 0, 0);
      chk("jmp_still_low", {31'b0, imem_req}, 32'd0);
      cyc(1, 0, 0, 0);
      chk("jmp_resume_addr", imem_addr, 32'h3004);

      // Async reset while draining a stale request.
      cyc(1, 0, 0, 0);
      cyc(1, 0, 1, 32'h4000);
      chk("drain_req", {31'b0, imem_req}, 32'd1);
      chk("drain_addr", imem_addr, 32'h3004);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_req", {31'b0, imem_req}, 32'd0);
      chk("arst_valid", {31'b0, out_valid}, 32'd0);
      chk("arst_instr", out_instr, 32'h0);
      chk("arst_pc", out_pc, 32'h0);
      imem_ack = 1'b0;
      redirect_valid = 1'b0;
      model_reset();
      mem_cnt = 0;
      mem_lat = 1;
      @(negedge clk);
      rst_n    = 1'b1;
      n8_rst_n = 1'b1;

      // Wrap-around on the 8-bit instance while the main one restarts.
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      cyc(1, 0, 0, 0);
      chk("wrap_out_pc_fc", {24'h0, n8_out_pc}, 32'h0000_00FC);
      chk("wrap_addr", {24'h0, n8_imem_addr}, 32'h0);
      cyc(1, 0, 0, 0);
      chk("wrap_out_pc_00", {24'h0, n8_out_pc}, 32'h0);
      chk("wrap_out_instr", n8_out_instr, 32'hC0DE_0000);
      chk("wrap_valid", {31'b0, n8_out_valid}, 32'd1);
      cyc(1, 0, 0, 0);
      compare();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
